// File: rtl/cacheline_burst_adaptor_pkg.sv
// Shared cache constants and the line/burst adaptor state encoding.
package cacheline_burst_adaptor_pkg;

   localparam int LINE_W      = 256;
   localparam int BURST_W     = 64;
   localparam int BEATS       = 4;
   localparam int OFFSET_BITS = 5;
   localparam int ADDR_W      = 32;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RD   = 2'd1,
      WR   = 2'd2,
      DONE = 2'd3
   } state_e;

endpackage

// File: rtl/cacheline_burst_adaptor_if.sv
// Cache-side request/line signals and memory-side burst signals of the adaptor.
// Handshake: the cache holds read_i/write_i until a one-cycle resp_o; the
// adaptor holds read_o/write_o for a whole burst and advances one beat on every
// cycle in which the memory raises resp_i (beat accepted on write, beat valid on read).
interface cacheline_burst_adaptor_if #(
   parameter int BURST_W = 64
);
   import cacheline_burst_adaptor_pkg::*;

   // cache side
   logic [LINE_W-1:0]  line_i;
   logic [LINE_W-1:0]  line_o;
   logic [ADDR_W-1:0]  address_i;
   logic               read_i;
   logic               write_i;
   logic               resp_o;
   // memory side
   logic [BURST_W-1:0] burst_i;
   logic [BURST_W-1:0] burst_o;
   logic [ADDR_W-1:0]  address_o;
   logic               read_o;
   logic               write_o;
   logic               resp_i;

   // the adaptor itself
   modport slave (
      input  line_i, address_i, read_i, write_i, burst_i, resp_i,
      output line_o, resp_o, burst_o, address_o, read_o, write_o
   );

   // the environment (cache + memory) around the adaptor
   modport master (
      output line_i, address_i, read_i, write_i, burst_i, resp_i,
      input  line_o, resp_o, burst_o, address_o, read_o, write_o
   );

endinterface

// File: rtl/cacheline_burst_adaptor.sv
// Turns a 256-bit cache line request into a 4-beat memory burst and back.
module cacheline_burst_adaptor #(
   parameter int BURST_W = 64,
   parameter int BEATS   = 4
) (
   input  logic                                  clk,
   input  logic                                  rst,
   cacheline_burst_adaptor_if.slave              bus,
   output cacheline_burst_adaptor_pkg::state_e   state_dbg
);
   import cacheline_burst_adaptor_pkg::*;

   localparam int                CNT_W    = $clog2(BEATS);
   localparam logic [CNT_W-1:0]  LAST_BEAT = CNT_W'(BEATS - 1);

   state_e                       state_q;
   state_e                       state_d;
   logic [CNT_W-1:0]             cnt_q;
   logic [ADDR_W-1:OFFSET_BITS]  addr_q;
   logic [LINE_W-1:0]            wline_q;
   logic [LINE_W-1:0]            rline_q;
   logic                         in_burst;
   logic                         beat;

   assign in_burst = (state_q == RD) || (state_q == WR);
   assign beat     = in_burst && bus.resp_i;

   // Next-state logic; a pending write wins over a pending read.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (bus.write_i)     state_d = WR;
            else if (bus.read_i) state_d = RD;
         end
         RD, WR: begin
            if (bus.resp_i && (cnt_q == LAST_BEAT)) state_d = DONE;
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // State, request capture, beat counting and read-line assembly.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         addr_q  <= '0;
         wline_q <= '0;
         rline_q <= '0;
      end else begin
         state_q <= state_d;
         if (state_q == IDLE && (bus.write_i || bus.read_i)) begin
            addr_q <= bus.address_i[ADDR_W-1:OFFSET_BITS];
            cnt_q  <= '0;
            if (bus.write_i) wline_q <= bus.line_i;
         end
         if (beat) cnt_q <= cnt_q + 1'b1;
         if (state_q == RD && bus.resp_i)
            rline_q[cnt_q*BURST_W +: BURST_W] <= bus.burst_i;
      end
   end

   assign bus.read_o    = (state_q == RD);
   assign bus.write_o   = (state_q == WR);
   assign bus.resp_o    = (state_q == DONE);
   assign bus.address_o = {addr_q, {OFFSET_BITS{1'b0}}};
   assign bus.burst_o   = wline_q[cnt_q*BURST_W +: BURST_W];
   assign bus.line_o    = rline_q;
   assign state_dbg     = state_q;

endmodule
